// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, valid/ready on both sides.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_m;
    logic [2*WIDTH:0]     r_p;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_shift;
    logic [2*WIDTH:0]     w_final;
    logic                 w_last;
    logic                 w_unused;

    // The carry-out of the add lands in the top bit and is shifted back into the high half.
    assign w_sum   = r_p[0] ? ({1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_m})
                            : {1'b0, r_p[2*WIDTH-1:WIDTH]};
    assign w_shift = {w_sum, r_p[WIDTH-1:0]} >> 1;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    logic [WIDTH-1:0] w_rem_mask;
    // After step 'count' the low WIDTH-1-count bits are the not-yet-consumed multiplier bits.
    assign w_rem_mask = {WIDTH{1'b1}} >> (r_count + 1'b1);
    assign w_last     = (r_count == LAST) || ((w_shift[WIDTH-1:0] & w_rem_mask) == '0);
    assign w_final    = w_shift >> (LAST - r_count);
`else
    assign w_last  = (r_count == LAST);
    assign w_final = w_shift;
`endif

    assign w_unused  = ^{r_p[2*WIDTH], w_final[2*WIDTH]};
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_p       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m     <= a;
                        r_p     <= {1'b0, {WIDTH{1'b0}}, b};
                        r_count <= '0;
                    end
                end
                RUN: begin
                    r_p     <= w_final;
                    r_count <= r_count + 1'b1;
                    if (w_last) r_product <= w_final[2*WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier (WIDTH=32); latency expectation follows SEQ_MUL_EARLY_EXIT_EN.
module tb_seq_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] product;

    seq_shift_add_multiplier #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] p;
        int          lat;
        longint      acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int exp_lat(input logic [31:0] bv);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        int m = 0;
        for (int i = 0; i < 32; i++) if (bv[i]) m = i + 1;
        return (m == 0) ? 1 : m;
`else
        return 32;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(input logic [31:0] av, input logic [31:0] bv, input logic [63:0] pexp);
        int   k = 0;
        exp_t e;
        while (!in_ready && k < 200) begin
            tick(1);
            k++;
        end
        if (k == 200) check("accept_timeout", 64'(in_ready), 64'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick(1);
        e.p = pexp;
        e.lat = exp_lat(bv);
        e.acc = cyc;
        exp_q.push_back(e);
        in_valid = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'hCAFEF00D;
    endtask

    task automatic wait_out();
        int k = 0;
        while (!out_valid && k < 100) begin
            tick(1);
            k++;
        end
        if (k == 100) check("result_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic handoff(input logic [63:0] pexp);
        wait_out();
        tick(1);
        check("idle_after_handoff", 64'({in_ready, out_valid}), 64'b10);
        check("product_held", product, pexp);
    endtask

    // Monitor: compares each new result against the scoreboard head.
    initial begin
        logic prev_ov = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e.p);
                    check("latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        tick(2);
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_product", product, 64'd0);

        start(32'd3, 32'd5, 64'h0F);
        handoff(64'h0F);

        start(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        handoff(64'hFFFFFFFE00000001);
        start(32'h80000000, 32'd2, 64'h100000000);
        handoff(64'h100000000);

        out_ready = 1'b0;
        start(32'd7, 32'd9, 64'd63);
        wait_out();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_product", product, 64'd63);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick(1);
        end
        out_ready = 1'b1;
        tick(1);
        check("bp_release", 64'({in_ready, out_valid}), 64'b10);

        start(32'd1234, 32'd5678, 64'd7006652);
        tick(3);
        a = 32'hFFFF;
        b = 32'hFFFF;
        in_valid = 1'b1;
        tick(3);
        check("busy_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        handoff(64'd7006652);
        tick(40);

        start(32'h12345, 32'hFFFFFFFF, 64'h12344FFFEDCBB);
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", product, 64'd0);
        start(32'd6, 32'd7, 64'd42);
        handoff(64'd42);
        tick(40);

        start(32'd0, 32'd5, 64'd0);
        handoff(64'd0);
        start(32'd5, 32'd0, 64'd0);
        handoff(64'd0);
        start(32'd9, 32'd1, 64'd9);
        handoff(64'd9);
        start(32'd3, 32'h80000000, 64'h180000000);
        handoff(64'h180000000);
        start(32'hFFFF, 32'h10001, 64'hFFFFFFFF);
        handoff(64'hFFFFFFFF);
        start(32'h80000000, 32'h80000000, 64'h4000000000000000);
        handoff(64'h4000000000000000);

        out_ready = 1'b1;
        tick(5);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
